// File: rtl/config_stream_loader.sv
// config_stream_loader
// Buffers configuration records from an upstream stream in a small FIFO,
// pops one record per cycle and turns every record addressed to this tile
// (or to the broadcast ID) into a one-cycle write strobe towards the tile.
// The record flagged "last" ends the load; after that the block idles until reset.

module config_stream_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BCAST_ID   = 16'hFFFF
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] tile_id,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_addr_in,
    input  logic [31:0] cfg_data_in,
    input  logic        cfg_last,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_write,
    output logic [15:0] write_count,
    output logic        busy,
    output logic        done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Record storage: {last, addr[31:0], data[31:0]}
    logic [64:0]    mem_r [FIFO_DEPTH];

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_nxt_s;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;

    logic           ready_r;
    logic           ready_nxt_s;
    logic           busy_r;
    logic           busy_nxt_s;
    logic [31:0]    addr_r;
    logic [31:0]    data_r;
    logic           write_r;
    logic [15:0]    wcount_r;
    logic [15:0]    wcount_nxt_s;
    logic           done_r;

    logic           push_s;
    logic           pop_s;
    logic           match_s;
    logic [64:0]    head_s;
    logic           head_last_s;
    logic [31:0]    head_addr_s;
    logic [31:0]    head_data_s;

    assign head_s      = mem_r[rd_ptr_r];
    assign head_last_s = head_s[64];
    assign head_addr_s = head_s[63:32];
    assign head_data_s = head_s[31:0];

    // Handshake uses only the registered ready, so there is no path from cfg_valid back to cfg_ready.
    assign push_s  = cfg_valid && ready_r;
    assign pop_s   = (state_r == ST_LOAD) && (count_r != ZERO_C);
    assign match_s = pop_s && ((head_addr_s[15:0] == tile_id) || (head_addr_s[15:0] == BCAST_ID));

    // Next-state, occupancy and next values of the registered status outputs.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        wcount_nxt_s = wcount_r;
        case (state_r)
            ST_LOAD: begin
                if (pop_s && head_last_s) begin
                    // Last record consumed: anything still buffered is dropped.
                    state_nxt_s = ST_DONE;
                    count_nxt_s = ZERO_C;
                end else if (push_s && !pop_s) begin
                    count_nxt_s = count_r + CW'(1'b1);
                end else if (!push_s && pop_s) begin
                    count_nxt_s = count_r - CW'(1'b1);
                end else begin
                    count_nxt_s = count_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
                count_nxt_s = ZERO_C;
            end
            default: begin
                state_nxt_s = ST_LOAD;
                count_nxt_s = ZERO_C;
            end
        endcase

        if (match_s && (wcount_r != 16'hFFFF)) begin
            wcount_nxt_s = wcount_r + 16'd1;
        end else begin
            wcount_nxt_s = wcount_r;
        end

        ready_nxt_s = (state_nxt_s == ST_LOAD) && (count_nxt_s != DEPTH_C);
        busy_nxt_s  = ((count_nxt_s != ZERO_C) && (state_nxt_s == ST_LOAD)) || match_s;
    end

    // Control state, pointers and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r  <= ST_LOAD;
            count_r  <= ZERO_C;
            wr_ptr_r <= AW'(1'b0);
            rd_ptr_r <= AW'(1'b0);
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            addr_r   <= 32'h0000_0000;
            data_r   <= 32'h0000_0000;
            write_r  <= 1'b0;
            wcount_r <= 16'h0000;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            ready_r  <= ready_nxt_s;
            busy_r   <= busy_nxt_s;
            write_r  <= match_s;
            wcount_r <= wcount_nxt_s;
            done_r   <= (state_nxt_s == ST_DONE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (match_s) begin
                addr_r <= head_addr_s;
                data_r <= head_data_s;
            end
        end
    end

    // Record storage write port; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_in) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= {cfg_last, cfg_addr_in, cfg_data_in};
        end
    end

    assign cfg_ready    = ready_r;
    assign busy         = busy_r;
    assign config_addr  = addr_r;
    assign config_data  = data_r;
    assign config_write = write_r;
    assign write_count  = wcount_r;
    assign done         = done_r;

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench for config_stream_loader: queue-based reference model,
// per-cycle comparison of every output, directed scenarios and random traffic.

module tb_config_stream_loader;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tile_id = 16'h0015;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_addr_in = 32'h0;
    logic [31:0] cfg_data_in = 32'h0;
    logic        cfg_last = 1'b0;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_write;
    logic [15:0] write_count;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    config_stream_loader #(.FIFO_DEPTH(DEPTH), .BCAST_ID(16'hFFFF)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .tile_id      (tile_id),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr_in  (cfg_addr_in),
        .cfg_data_in  (cfg_data_in),
        .cfg_last     (cfg_last),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_write (config_write),
        .write_count  (write_count),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        last;
        logic [31:0] a;
        logic [31:0] d;
    } rec_t;

    rec_t        mq[$];
    bit          m_init = 1'b0;
    bit          m_done, m_write, m_ready, m_busy;
    logic [31:0] m_addr, m_data;
    int          m_count;

    always @(posedge clk_in) begin : model
        rec_t r;
        bit   push;
        if (reset) begin
            mq.delete();
            m_init  = 1'b1;
            m_done  = 1'b0;
            m_write = 1'b0;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_addr  = 32'h0;
            m_data  = 32'h0;
            m_count = 0;
        end else if (m_init) begin
            push    = cfg_valid && m_ready;
            m_write = 1'b0;
            if (!m_done && mq.size() > 0) begin
                r = mq.pop_front();
                if (r.a[15:0] == tile_id || r.a[15:0] == 16'hFFFF) begin
                    m_addr  = r.a;
                    m_data  = r.d;
                    m_write = 1'b1;
                    if (m_count < 65535) m_count++;
                end
                if (r.last) m_done = 1'b1;
            end
            if (push) begin
                r.last = cfg_last;
                r.a    = cfg_addr_in;
                r.d    = cfg_data_in;
                mq.push_back(r);
            end
            if (m_done) mq.delete();
            m_ready = !m_done && (mq.size() < DEPTH);
            m_busy  = (!m_done && mq.size() != 0) || m_write;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] seen[$];

    always @(negedge clk_in) begin
        if (m_init) begin
            chk("cfg_ready",    32'(cfg_ready),    32'(m_ready));
            chk("config_write", 32'(config_write), 32'(m_write));
            chk("config_addr",  config_addr,       m_addr);
            chk("config_data",  config_data,       m_data);
            chk("write_count",  32'(write_count),  32'(m_count));
            chk("busy",         32'(busy),         32'(m_busy));
            chk("done",         32'(done),         32'(m_done));
            if (config_write) seen.push_back(config_addr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset(input logic [15:0] t);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        reset     = 1'b1;
        tile_id   = t;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic set_rec(input logic [31:0] a, input logic [31:0] d, input logic l);
        cfg_valid   = 1'b1;
        cfg_addr_in = a;
        cfg_data_in = d;
        cfg_last    = l;
    endtask

    initial begin
        // Reset state
        do_reset(16'h0015);
        chk("rst_ready",  32'(cfg_ready),    32'd0);
        chk("rst_wcount", 32'(write_count),  32'd0);
        chk("rst_done",   32'(done),         32'd0);
        chk("rst_write",  32'(config_write), 32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        cyc();
        chk("ready_after_rst", 32'(cfg_ready), 32'd1);

        // Single matched last record: strobe two edges after the push
        set_rec(32'h0003_0015, 32'h0000_01EA, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        chk("lat_no_strobe_yet", 32'(config_write), 32'd0);
        cyc();
        chk("single_write", 32'(config_write), 32'd1);
        chk("single_addr",  config_addr, 32'h0003_0015);
        chk("single_data",  config_data, 32'h0000_01EA);
        chk("single_count", 32'(write_count), 32'd1);
        chk("single_done",  32'(done), 32'd1);
        cyc();
        chk("single_pulse_end", 32'(config_write), 32'd0);
        chk("single_ready_low", 32'(cfg_ready),    32'd0);

        // Three records, middle one for another tile
        do_reset(16'h0015);
        cyc();
        set_rec(32'h0001_0015, 32'hAAAA_0001, 1'b0);
        cyc();
        set_rec(32'h0002_0022, 32'hBBBB_0002, 1'b0);
        cyc();
        chk("three_w1",   32'(config_write), 32'd1);
        chk("three_a1",   config_addr, 32'h0001_0015);
        set_rec(32'h0003_0015, 32'hCCCC_0003, 1'b0);
        cyc();
        cfg_valid = 1'b0;
        chk("three_gap_w",    32'(config_write), 32'd0);
        chk("three_gap_hold", config_addr, 32'h0001_0015);
        cyc();
        chk("three_w3", 32'(config_write), 32'd1);
        chk("three_a3", config_addr, 32'h0003_0015);
        cyc(2);
        chk("three_count", 32'(write_count), 32'd2);

        // Broadcast record reaches two different tiles
        for (int k = 0; k < 2; k++) begin
            do_reset((k == 0) ? 16'h0015 : 16'h0007);
            cyc();
            set_rec(32'h0005_FFFF, 32'h0000_BCA5, 1'b0);
            cyc();
            cfg_valid = 1'b0;
            cyc();
            chk("bcast_write", 32'(config_write), 32'd1);
            chk("bcast_addr",  config_addr, 32'h0005_FFFF);
            chk("bcast_count", 32'(write_count), 32'd1);
        end

        // Ten back-to-back records
        do_reset(16'h0015);
        cyc();
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            set_rec({16'(i + 1), 16'h0015}, 32'(i * 3), 1'b0);
            chk("stream_ready", 32'(cfg_ready), 32'd1);
            cyc();
        end
        cfg_valid = 1'b0;
        cyc(3);
        chk("stream_count", 32'(write_count), 32'd10);
        chk("stream_nwrites", 32'(seen.size()), 32'd10);
        for (int i = 0; i < 10 && i < seen.size(); i++) begin
            chk("stream_order", seen[i], {16'(i + 1), 16'h0015});
        end

        // Records after the last one are ignored
        do_reset(16'h0015);
        cyc();
        seen.delete();
        set_rec(32'h0009_0015, 32'h0000_0009, 1'b1);
        cyc();
        set_rec(32'h000A_0015, 32'h0000_000A, 1'b0);
        cyc();
        set_rec(32'h000B_0015, 32'h0000_000B, 1'b0);
        cyc();
        cfg_valid = 1'b0;
        cyc(3);
        chk("after_last_count", 32'(write_count), 32'd1);
        chk("after_last_done",  32'(done), 32'd1);
        chk("after_last_ready", 32'(cfg_ready), 32'd0);
        chk("after_last_nwr",   32'(seen.size()), 32'd1);

        // Reset mid-stream with a strobe in flight
        do_reset(16'h0015);
        cyc();
        set_rec(32'h0011_0015, 32'h11, 1'b0);
        cyc();
        set_rec(32'h0012_0015, 32'h12, 1'b0);
        cyc();
        set_rec(32'h0013_0015, 32'h13, 1'b0);
        cyc();
        cfg_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        seen.delete();
        chk("midrst_write",  32'(config_write), 32'd0);
        chk("midrst_count",  32'(write_count),  32'd0);
        chk("midrst_done",   32'(done),         32'd0);
        chk("midrst_busy",   32'(busy),         32'd0);
        cyc();
        chk("midrst_ready",  32'(cfg_ready), 32'd1);
        cyc(3);
        chk("midrst_nwr",    32'(seen.size()), 32'd0);
        chk("midrst_count2", 32'(write_count), 32'd0);

        // Random traffic against the model
        for (int rnd = 0; rnd < 8; rnd++) begin
            case ($urandom_range(0, 2))
                0:       do_reset(16'h0015);
                1:       do_reset(16'h0007);
                default: do_reset(16'h0022);
            endcase
            cyc();
            for (int c = 0; c < 300; c++) begin
                logic [15:0] tf;
                case ($urandom_range(0, 3))
                    0:       tf = 16'hFFFF;
                    1:       tf = 16'($urandom_range(0, 65535));
                    default: tf = tile_id;
                endcase
                cfg_valid   = ($urandom_range(0, 3) != 0);
                cfg_addr_in = {16'($urandom_range(0, 65535)), tf};
                cfg_data_in = $urandom;
                cfg_last    = ($urandom_range(0, 80) == 0);
                reset       = ($urandom_range(0, 150) == 0);
                cyc();
            end
            reset = 1'b0;
        end

        cfg_valid = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
